flag_frame_collector: RTL and testbench
=======================================

// Module: flag_frame_collector
// PURPOSE
//  Upstream producer for the cond/data gating stage. Collects a frame of NFLAGS (flag, data) beats on a
//  valid/ready stream and counts the set flags. Emits one result per frame: a 1-bit cond, the flag
//  count, and the data word of the frame's last beat. The result is held until the consumer accepts it.
// PARAMETERS
//  DATA_W  8  width of data word carried with each beat
//  NFLAGS  4  beats (flags) per frame, >=1
//  CNT_W   $clog2(NFLAGS+1)  derived localparam; width of flag count
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous reset, active-low
//  in_valid   in   1       input beat valid
//  in_ready   out  1       input beat accepted when in_valid&&in_ready
//  in_flag    in   1       flag bit of beat
//  in_data    in   DATA_W  data of beat
//  in_flush   in   1       discard partial frame
//  out_valid  out  1       frame result valid
//  out_ready  in   1       consumer accepts result
//  out_cond   out  1       frame condition (see CONFIGURATION)
//  out_cnt    out  CNT_W   number of set flags in frame, 0..NFLAGS
//  out_data   out  DATA_W  in_data of frame's final beat
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, beat cnt=0, flag acc=0; out_valid=0, out_cond=0, out_cnt=0,
//    out_data=0. Reset mid-frame or mid-HOLD discards everything; no result is emitted.
//  - FSM states:
//    - IDLE: no beats held.
//    - COLLECT: 1..NFLAGS-1 beats held.
//    - HOLD: result registered, out_valid=1.
//  - in_ready = !in_flush && (state!=HOLD || out_ready). Combinational; no in_valid->in_ready path.
//  - Accepted beat: flag acc += in_flag; beat cnt += 1. When a beat completes the frame
//    (beat cnt reaches NFLAGS):
//    - next cycle out_valid=1, out_cnt=acc incl. this beat, out_data=this beat's in_data, out_cond per config;
//    - state=HOLD; acc and beat cnt clear to 0.
//  - Latency: final beat accepted at edge N -> out_valid high after edge N. NFLAGS=1 gives 1 cycle/frame.
//  - HOLD: out_* stable while out_valid&&!out_ready. At out_ready, result retires on that edge.
//    - If a beat is accepted in the same cycle, it starts the next frame: COLLECT, or HOLD with new
//      result if NFLAGS==1. Otherwise the block goes to IDLE.
//    - Full throughput: no bubble is needed.
//  - in_flush in IDLE/COLLECT: acc and beat cnt clear, state=IDLE, beat in same cycle not accepted
//    (in_ready=0). in_flush in HOLD: pending result kept; flush only blocks input that cycle.
//  - Count arithmetic: acc is CNT_W bits and cannot overflow (max NFLAGS). No wrap logic.
// CONFIGURATION
//  FLAG_PARITY_EN defined:   out_cond = LSB of flag count (XOR of flags), matching a 1-bit sum.
//  FLAG_PARITY_EN undefined: out_cond = (out_cnt != 0), i.e. OR of flags.
//  out_cnt is identical in both builds.
// STRUCTURE
//  - Package flag_frame_pkg: state enum {IDLE, COLLECT, HOLD} and a cond_from_cnt function.
//    The function carries the `ifdef FLAG_PARITY_EN choice.
//  - Sub-module flag_popcnt_acc: beat counter and flag accumulator with clear/incr/frame_done.
//    The FSM and output register stay in the top level.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles with in_valid=1.
//    -> out_valid=0, out_cnt=0, out_data=0; no beat counted after release.
//  - Frame flags 1,0,1,1 with data 8'h11,22,33,44, out_ready=1.
//    -> out_valid 1 cycle after 4th beat; out_cnt=3, out_data=8'h44; out_cond=1 (both builds).
//  - Frame flags 1,1,0,0.
//    -> out_cnt=2; out_cond=0 with FLAG_PARITY_EN, 1 without. Flags 0,0,0,0 -> out_cnt=0, out_cond=0.
//  - Backpressure: out_ready=0 for 5 cycles after result.
//    -> in_ready=0, outputs stable. Raising out_ready with in_valid=1 accepts the next beat that same cycle.
//  - Flush: 2 beats (flags 1,1), then in_flush=1 with in_valid=1.
//    -> beat dropped; the next full frame of 0,0,0,1 yields out_cnt=1.
//  - Reset asserted during HOLD.
//    -> out_valid=0 next cycle; the subsequent frame counts from zero.

Source files
------------

// File: rtl/flag_frame_pkg.sv
// Shared types and helpers for the flag frame collector.
// Build option: FLAG_PARITY_EN selects the frame condition:
// parity of the flag count when defined, OR of the flags otherwise.
package flag_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // The count arrives zero-extended to 32 bits, so one function works for any CNT_W.
  function automatic logic cond_from_cnt(input logic [31:0] cnt);
`ifdef FLAG_PARITY_EN
    return (cnt % 32'd2) != 32'd0;
`else
    return cnt != 32'd0;
`endif
  endfunction

endpackage

// File: rtl/flag_popcnt_acc.sv
// Beat counter and set-flag accumulator for one frame.
// The accumulator clears on flush and on frame completion. It exposes the
// accumulated count including the current beat, so the result can be
// registered on the same edge that accepts the final beat.
module flag_popcnt_acc #(
  parameter int NFLAGS = 4,
  parameter int CNT_W  = $clog2(NFLAGS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             incr_i,
  input  logic             flag_i,
  output logic [CNT_W-1:0] acc_next_o,
  output logic             frame_done_o
);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;

  // Completion and next-count decode for the current beat.
  always_comb begin
    acc_next_o   = acc_q + CNT_W'(flag_i);
    frame_done_o = incr_i && (beat_cnt_q == CNT_W'(NFLAGS - 1));
    beat_cnt_d   = beat_cnt_q;
    acc_d        = acc_q;
    if (clear_i || frame_done_o) begin
      beat_cnt_d = '0;
      acc_d      = '0;
    end else if (incr_i) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      acc_d      = acc_next_o;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      acc_q      <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: rtl/flag_frame_collector.sv
// Collects NFLAGS (flag, data) beats per frame. It emits the set-flag count,
// a condition bit, and the data of the last beat. The result is held until
// the consumer accepts it.
// Build option: FLAG_PARITY_EN (see flag_frame_pkg::cond_from_cnt).
//
//   state   | meaning
//   IDLE    | no beats held
//   COLLECT | 1..NFLAGS-1 beats held
//   HOLD    | result registered, out_valid=1
module flag_frame_collector
  import flag_frame_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NFLAGS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_flag,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_cond,
  output logic [$clog2(NFLAGS+1)-1:0]   out_cnt,
  output logic [DATA_W-1:0]             out_data
);

  localparam int CNT_W = $clog2(NFLAGS + 1);

  state_e           state_q;
  logic             out_valid_q;
  logic             out_cond_q, out_cond_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] out_data_q;

  logic             accept;
  logic             frame_done;
  logic [CNT_W-1:0] acc_next;

  // In HOLD, input opens only when the held result retires on the same edge.
  assign in_ready = !in_flush && ((state_q != HOLD) || out_ready);
  assign accept   = in_valid && in_ready;

  flag_popcnt_acc #(
    .NFLAGS (NFLAGS),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (in_flush),
    .incr_i       (accept),
    .flag_i       (in_flag),
    .acc_next_o   (acc_next),
    .frame_done_o (frame_done)
  );

  // Result that would be registered if this beat completes the frame.
  always_comb begin
    out_cnt_d  = acc_next;
    out_cond_d = cond_from_cnt(32'(acc_next));
  end

  // Frame sequencing FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_cond_q  <= 1'b0;
      out_cnt_q   <= '0;
      out_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE, COLLECT: begin
          if (in_flush) begin
            state_q <= IDLE;
          end else if (accept) begin
            if (frame_done) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_cond_q  <= out_cond_d;
              out_cnt_q   <= out_cnt_d;
              out_data_q  <= in_data;
            end else begin
              state_q <= COLLECT;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (accept && frame_done) begin
              // Back-to-back single-beat frames: replace the result in place.
              out_valid_q <= 1'b1;
              out_cond_q  <= out_cond_d;
              out_cnt_q   <= out_cnt_d;
              out_data_q  <= in_data;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= accept ? COLLECT : IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_cond  = out_cond_q;
  assign out_cnt   = out_cnt_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_flag_frame_collector.sv
// Scoreboard bench for flag_frame_collector: directed scenarios then random traffic.
module tb_flag_frame_collector;

  localparam int DATA_W = 8;
  localparam int NFLAGS = 4;
  localparam int CNT_W  = $clog2(NFLAGS + 1);

  typedef struct {
    logic [CNT_W-1:0]  cnt;
    logic              cond;
    logic [DATA_W-1:0] data;
  } res_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_flag;
  logic [DATA_W-1:0] in_data;
  logic              in_flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_cond;
  logic [CNT_W-1:0]  out_cnt;
  logic [DATA_W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  res_t exp_q[$];
  bit   part_flags[$];

  flag_frame_collector #(.DATA_W(DATA_W), .NFLAGS(NFLAGS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flag   (in_flag),
    .in_data   (in_data),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cond  (out_cond),
    .out_cnt   (out_cnt),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_cond(input int cnt);
`ifdef FLAG_PARITY_EN
    return (cnt % 2) == 1;
`else
    return cnt > 0;
`endif
  endfunction

  // Monitor + reference model: inputs are stable at negedge and apply to the next posedge.
  always @(negedge clk) begin : mon
    bit   pend;
    bit   rdy;
    int   sum;
    res_t r;
    if (!rst_n) begin
      exp_q.delete();
      part_flags.delete();
    end else begin
      pend = (exp_q.size() > 0);
      rdy  = !in_flush && (!pend || out_ready);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      chk("out_valid", 32'(out_valid), 32'(pend));
      if (out_valid && pend) begin
        chk("out_cnt", 32'(out_cnt), 32'(exp_q[0].cnt));
        chk("out_cond", 32'(out_cond), 32'(exp_q[0].cond));
        chk("out_data", 32'(out_data), 32'(exp_q[0].data));
      end
      if (pend && out_ready) void'(exp_q.pop_front());
      if (in_flush) begin
        part_flags.delete();
      end else if (in_valid && rdy) begin
        part_flags.push_back(in_flag);
        if (part_flags.size() == NFLAGS) begin
          sum = 0;
          foreach (part_flags[i]) sum += int'(part_flags[i]);
          r.cnt  = CNT_W'(sum);
          r.cond = exp_cond(sum);
          r.data = in_data;
          exp_q.push_back(r);
          part_flags.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat until accepted; reports how many edges it took.
  task automatic send_beat(input logic f, input logic [DATA_W-1:0] d, output int edges);
    bit done;
    done  = 1'b0;
    edges = 0;
    in_valid = 1'b1;
    in_flag  = f;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      tick();
      edges++;
      if (!done && edges > 100) begin
        chk("send_timeout", 32'(edges), 32'd0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] flags, input logic [4*DATA_W-1:0] datas);
    int e;
    for (int i = 0; i < NFLAGS; i++)
      send_beat(flags[3-i], datas[(3-i)*DATA_W +: DATA_W], e);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_flag   = 1'b1;
    in_data   = 8'hA5;
    in_flush  = 1'b0;
    out_ready = 1'b1;

    // Reset held with in_valid high.
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_cond", 32'(out_cond), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();

    // Basic frames.
    send_frame(4'b1011, {8'h11, 8'h22, 8'h33, 8'h44});
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("first_cnt", 32'(out_cnt), 32'd3);
    chk("first_data", 32'(out_data), 32'h44);
    chk("first_cond", 32'(out_cond), 32'd1);
    tick();
    send_frame(4'b1100, {8'h55, 8'h66, 8'h77, 8'h88});
    tick();
    send_frame(4'b0000, {8'h99, 8'hAA, 8'hBB, 8'hCC});
    chk("zero_cnt", 32'(out_cnt), 32'd0);
    chk("zero_cond", 32'(out_cond), 32'd0);
    tick();

    // Backpressure: result held, input blocked, then accepted on the retire edge.
    out_ready = 1'b0;
    send_frame(4'b0111, {8'h01, 8'h02, 8'h03, 8'h04});
    in_valid = 1'b1;
    in_flag  = 1'b1;
    in_data  = 8'h5A;
    repeat (5) tick();
    chk("bp_cnt_held", 32'(out_cnt), 32'd3);
    chk("bp_data_held", 32'(out_data), 32'h04);
    out_ready = 1'b1;
    send_beat(1'b1, 8'h5A, e);
    chk("bp_accept_same_cycle", 32'(e), 32'd1);
    send_beat(1'b0, 8'h5B, e);
    send_beat(1'b0, 8'h5C, e);
    send_beat(1'b1, 8'h5D, e);
    tick();

    // Flush drops the partial frame and the beat offered with it.
    send_beat(1'b1, 8'hE1, e);
    send_beat(1'b1, 8'hE2, e);
    in_valid = 1'b1;
    in_flush = 1'b1;
    in_flag  = 1'b1;
    in_data  = 8'hE3;
    tick();
    in_flush = 1'b0;
    in_valid = 1'b0;
    send_frame(4'b0001, {8'hF1, 8'hF2, 8'hF3, 8'hF4});
    chk("flush_cnt", 32'(out_cnt), 32'd1);
    tick();

    // Reset during HOLD.
    out_ready = 1'b0;
    send_frame(4'b1111, {8'hC1, 8'hC2, 8'hC3, 8'hC4});
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_frame(4'b1000, {8'hD1, 8'hD2, 8'hD3, 8'hD4});
    chk("after_rst_cnt", 32'(out_cnt), 32'd1);
    tick();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_flag   = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_flush  = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Drain.
    in_valid  = 1'b0;
    in_flush  = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
